// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO: shift-add multiply,
// restoring divide, one step per cycle over WIDTH iterations.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [1:0]           op_q;
  logic [2*WIDTH-1:0]   acc, acc_step, prod_fix;
  logic [CW-1:0]        cnt;
  logic                 sign_q, sign_r;
  logic                 is_div, is_signed, div_zero;
  logic [WIDTH-1:0]     mag_a, mag_b, div_diff, quo_fix, rem_fix;
  logic [WIDTH:0]       mul_sum, div_top;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign div_zero  = is_div && (b_q == '0);
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PREP;
      PREP:    state_nx = div_zero ? FIX : ITER;
      ITER:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    div_top  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_top[WIDTH-1:0] - b_q;
    if (is_div)
      acc_step = (div_top >= {1'b0, b_q}) ? {div_diff, acc[WIDTH-2:0], 1'b1}
                                          : {div_top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= srca;
            b_q  <= srcb;
            op_q <= op;
          end else begin
            if (mthi) hi <= srca;
            if (mtlo) lo <= srca;
          end
        end
        PREP: begin
          cnt    <= '0;
          sign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= is_signed & a_q[WIDTH-1];
          // Divide-by-zero result is preloaded and the sign fixup disabled.
          if (div_zero) begin
            acc    <= {a_q, {WIDTH{1'b1}}};
            sign_q <= 1'b0;
            sign_r <= 1'b0;
          end else if (is_div) begin
            acc <= {{WIDTH{1'b0}}, mag_a};
            b_q <= mag_b;
          end else begin
            acc <= {{WIDTH{1'b0}}, mag_b};
            a_q <= mag_a;
          end
        end
        ITER: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
